alu_despachador: RTL and testbench
==================================

# alu_despachador

Sequencing front-end for the 8-bit ALU. It accepts one operation at a time over a valid/ready handshake and registers the opcode and operands. It drives them into the ALU, waits a fixed settling time, and captures `Resultado`. It then holds the result on an output valid/ready handshake until it is consumed. This block sits directly upstream of `alu_top`: it drives `Codigo_OP`, `Dato0` and `Dato1`, and it consumes `Resultado`.

## Interface
Parameters:
- `ANCHO`, 8 — data width; must match the ALU (8).
- `ESPERA`, 1 — cycles the ALU inputs are held stable before `Resultado` is sampled; legal range 1..15.

Ports:
- `clk`  input  1  — single clock; all state changes on the rising edge.
- `rst_n`  input  1  — asynchronous, active-low reset.
- `ent_valido`  input  1  — request valid.
- `ent_listo`  output  1  — block can accept a request.
- `ent_codigo`  input  3  — opcode: 000 add, 001 sub, 010 mul, 011 div, 100 mod.
- `ent_dato0`  input  ANCHO  — first operand.
- `ent_dato1`  input  ANCHO  — second operand.
- `Codigo_OP`  output  3  — registered opcode to the ALU.
- `Dato0`  output  ANCHO  — registered operand to the ALU.
- `Dato1`  output  ANCHO  — registered operand to the ALU.
- `Resultado`  input  ANCHO  — ALU result (combinational).
- `sal_valido`  output  1  — result valid.
- `sal_listo`  input  1  — consumer ready.
- `sal_resultado`  output  ANCHO  — captured result.
- `sal_error`  output  1  — request rejected; see Configuration.

## Operation
- FSM states: LIBRE, EJECUTA, ENTREGA.
- LIBRE:
  - `ent_listo`=1.
  - On `ent_valido`&&`ent_listo`, register `ent_codigo`/`ent_dato0`/`ent_dato1` into `Codigo_OP`/`Dato0`/`Dato1`, clear the wait counter, and go to EJECUTA.
- EJECUTA:
  - `ent_listo`=0.
  - The wait counter increments each cycle.
  - On the cycle where counter == ESPERA-1, capture `Resultado` into `sal_resultado`, clear `sal_error`, and go to ENTREGA.
- ENTREGA:
  - `sal_valido`=1.
  - `sal_resultado` and `sal_error` are held stable.
  - On `sal_valido`&&`sal_listo`, go to LIBRE.
  - A new request is never accepted in the same cycle as the output handshake.
- `Codigo_OP`/`Dato0`/`Dato1` change only on an accepted request. They hold between requests.
- No arithmetic in this block. The `Resultado` width is passed through unchanged, and overflow/truncation semantics belong to the ALU.
- Reset value of every output:
  - `ent_listo`=0, `sal_valido`=0, `sal_error`=0.
  - `sal_resultado`=0, `Codigo_OP`=0, `Dato0`=0, `Dato1`=0.
  - State LIBRE.
  - `ent_listo` rises on the first rising edge after `rst_n` deasserts.
- Reset mid-operation: all state is dropped immediately; no result is produced for the in-flight request.

## Timing
- `ent_listo` and `sal_valido` are registered; they are not combinational from the handshake inputs.
- Request accepted at edge T → ALU inputs valid from T → `sal_valido`=1 from edge T+ESPERA+1.
- Minimum request-to-request period with `sal_listo` tied 1: ESPERA+3 cycles.
- `ent_valido` while `ent_listo`=0 is ignored. The requester holds the request; nothing is dropped or latched.
- `sal_listo` outside ENTREGA has no effect.

## Configuration
- Macro `ALU_DESPACHADOR_CHEQUEO_EN`.
- Defined:
  - Requests with opcode 101–111, or with opcode 011/100 and `ent_dato1`==0, are rejected at acceptance.
  - A rejected request goes LIBRE→ENTREGA directly, so `sal_valido`=1 at edge T+1.
  - It sets `sal_resultado`=8'hFF and `sal_error`=1.
  - `Codigo_OP`/`Dato0`/`Dato1` are not updated.
- Not defined:
  - Every request follows the EJECUTA path.
  - `sal_error` is a constant 0.
  - The ALU output for illegal/zero-divisor requests is returned as is.

## Test plan
- Reset release, ESPERA=1, request 000/8'h12/8'h34, `sal_listo`=1 → `ent_listo` 0 during reset, 1 after the first edge; `sal_valido` two edges after acceptance; `sal_resultado`=8'h46; `sal_error`=0.
- ESPERA=3, request 010/8'h05/8'h06 → `sal_valido` four edges after acceptance; `sal_resultado`=8'h1E; `Dato0`/`Dato1` stable throughout EJECUTA.
- Backpressure: `sal_listo`=0 for 5 cycles in ENTREGA, new `ent_valido` asserted meanwhile → `sal_resultado` held; `ent_listo`=0; new request accepted only in the cycle after the output handshake.
- With the macro defined, request 011/8'h09/8'h00 and then opcode 110 → each gives `sal_valido` at T+1 with `sal_resultado`=8'hFF, `sal_error`=1, and `Dato1` unchanged. Without the macro, the same requests take the EJECUTA path with `sal_error`=0.
- Assert `rst_n` low during EJECUTA → all outputs 0 asynchronously; after release, no stale `sal_valido`; the next request completes normally.

Source files
------------

// File: rtl/alu_despachador.sv
// Sequencing front-end for the 8-bit ALU: accepts a request, holds the ALU inputs for ESPERA cycles,
// captures Resultado and offers it on an output handshake. Optional request checking: ALU_DESPACHADOR_CHEQUEO_EN.
module alu_despachador #(
  parameter int ANCHO  = 8,
  parameter int ESPERA = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ent_valido,
  output logic             ent_listo,
  input  logic [2:0]       ent_codigo,
  input  logic [ANCHO-1:0] ent_dato0,
  input  logic [ANCHO-1:0] ent_dato1,
  output logic [2:0]       Codigo_OP,
  output logic [ANCHO-1:0] Dato0,
  output logic [ANCHO-1:0] Dato1,
  input  logic [ANCHO-1:0] Resultado,
  output logic             sal_valido,
  input  logic             sal_listo,
  output logic [ANCHO-1:0] sal_resultado,
  output logic             sal_error
);

  typedef enum logic [1:0] {LIBRE, EJECUTA, ENTREGA} estado_t;

  localparam logic [3:0] ULTIMA = 4'(ESPERA - 1);

  estado_t          state_reg, state_next;
  logic [3:0]       cuenta_reg, cuenta_next;
  logic             ent_listo_reg, ent_listo_next;
  logic             sal_valido_reg, sal_valido_next;
  logic             sal_error_reg, sal_error_next;
  logic [ANCHO-1:0] sal_resultado_reg, sal_resultado_next;
  logic [2:0]       codigo_reg, codigo_next;
  logic [ANCHO-1:0] dato0_reg, dato0_next;
  logic [ANCHO-1:0] dato1_reg, dato1_next;
  logic             acepta;
  logic             rechaza;

  assign acepta = ent_valido && ent_listo_reg;

`ifdef ALU_DESPACHADOR_CHEQUEO_EN
  // Unknown opcodes and zero divisors never reach the ALU.
  assign rechaza = (ent_codigo > 3'd4) ||
                   (((ent_codigo == 3'd3) || (ent_codigo == 3'd4)) && (ent_dato1 == '0));
`else
  assign rechaza = 1'b0;
`endif

  always_comb begin
    state_next         = state_reg;
    cuenta_next        = cuenta_reg;
    sal_error_next     = sal_error_reg;
    sal_resultado_next = sal_resultado_reg;
    codigo_next        = codigo_reg;
    dato0_next         = dato0_reg;
    dato1_next         = dato1_reg;
    case (state_reg)
      LIBRE: begin
        if (acepta) begin
          if (rechaza) begin
            sal_resultado_next = '1;
            sal_error_next     = 1'b1;
            state_next         = ENTREGA;
          end else begin
            codigo_next = ent_codigo;
            dato0_next  = ent_dato0;
            dato1_next  = ent_dato1;
            cuenta_next = '0;
            state_next  = EJECUTA;
          end
        end
      end
      EJECUTA: begin
        cuenta_next = cuenta_reg + 4'd1;
        if (cuenta_reg == ULTIMA) begin
          sal_resultado_next = Resultado;
          sal_error_next     = 1'b0;
          state_next         = ENTREGA;
        end
      end
      ENTREGA: begin
        if (sal_valido_reg && sal_listo) state_next = LIBRE;
      end
      default: state_next = LIBRE;
    endcase
    // Output valid rises one cycle after entering ENTREGA and drops on the handshake edge itself.
    ent_listo_next  = (state_next == LIBRE);
    sal_valido_next = (state_reg == ENTREGA) && (state_next == ENTREGA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= LIBRE;
      cuenta_reg        <= '0;
      ent_listo_reg     <= 1'b0;
      sal_valido_reg    <= 1'b0;
      sal_error_reg     <= 1'b0;
      sal_resultado_reg <= '0;
      codigo_reg        <= '0;
      dato0_reg         <= '0;
      dato1_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      cuenta_reg        <= cuenta_next;
      ent_listo_reg     <= ent_listo_next;
      sal_valido_reg    <= sal_valido_next;
      sal_error_reg     <= sal_error_next;
      sal_resultado_reg <= sal_resultado_next;
      codigo_reg        <= codigo_next;
      dato0_reg         <= dato0_next;
      dato1_reg         <= dato1_next;
    end
  end

  assign ent_listo     = ent_listo_reg;
  assign sal_valido    = sal_valido_reg;
  assign sal_resultado = sal_resultado_reg;
  assign Codigo_OP     = codigo_reg;
  assign Dato0         = dato0_reg;
  assign Dato1         = dato1_reg;
`ifdef ALU_DESPACHADOR_CHEQUEO_EN
  assign sal_error     = sal_error_reg;
`else
  assign sal_error     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_despachador.sv
// Self-checking bench for alu_despachador: behavioural ALU on Resultado, directed and random requests
// checked for latency, result, error flag, operand stability, backpressure and reset.
module tb_alu_despachador;

  localparam int E = 3;
`ifdef ALU_DESPACHADOR_CHEQUEO_EN
  localparam bit CHEQ = 1'b1;
`else
  localparam bit CHEQ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ent_valido = 1'b0;
  logic       ent_listo;
  logic [2:0] ent_codigo = '0;
  logic [7:0] ent_dato0 = '0;
  logic [7:0] ent_dato1 = '0;
  logic [2:0] Codigo_OP;
  logic [7:0] Dato0, Dato1, Resultado;
  logic       sal_valido;
  logic       sal_listo = 1'b0;
  logic [7:0] sal_resultado;
  logic       sal_error;

  int checks = 0;
  int errors = 0;
  logic [2:0] last_op = '0;
  logic [7:0] last_a = '0, last_b = '0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      3'd0: r = int'(a) + int'(b);
      3'd1: r = int'(a) - int'(b);
      3'd2: r = int'(a) * int'(b);
      3'd3: r = (b == 0) ? 255 : int'(a) / int'(b);
      3'd4: r = (b == 0) ? int'(a) : int'(a) % int'(b);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  assign Resultado = alu_model(Codigo_OP, Dato0, Dato1);

  alu_despachador #(.ANCHO(8), .ESPERA(E)) dut (
    .clk(clk), .rst_n(rst_n),
    .ent_valido(ent_valido), .ent_listo(ent_listo),
    .ent_codigo(ent_codigo), .ent_dato0(ent_dato0), .ent_dato1(ent_dato1),
    .Codigo_OP(Codigo_OP), .Dato0(Dato0), .Dato1(Dato1),
    .Resultado(Resultado),
    .sal_valido(sal_valido), .sal_listo(sal_listo),
    .sal_resultado(sal_resultado), .sal_error(sal_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One request end to end; bp = cycles of sal_listo=0 once the result is offered.
  task automatic do_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int bp);
    bit rej;
    int lat;
    logic [7:0] exp_res;
    for (int i = 0; i < 50 && !ent_listo; i++) step();
    check("listo_espera", 32'(ent_listo), 32'd1);
    rej = CHEQ && ((op > 3'd4) || (((op == 3'd3) || (op == 3'd4)) && (b == 8'd0)));
    exp_res = rej ? 8'hFF : alu_model(op, a, b);
    ent_valido = 1'b1; ent_codigo = op; ent_dato0 = a; ent_dato1 = b;
    sal_listo = (bp == 0);
    step();
    if (!rej) begin last_op = op; last_a = a; last_b = b; end
    // Keep a bogus request pending; it must be ignored while busy.
    ent_codigo = 3'($urandom); ent_dato0 = 8'($urandom); ent_dato1 = 8'($urandom);
    lat = 0;
    while (!sal_valido && lat < 40) begin
      check("listo_ocupado", 32'(ent_listo), 32'd0);
      check("operandos", {13'd0, Codigo_OP, Dato0, Dato1}, {13'd0, last_op, last_a, last_b});
      step();
      lat++;
    end
    check("latencia", 32'(lat), rej ? 32'd1 : 32'(E + 1));
    check("resultado", 32'(sal_resultado), 32'(exp_res));
    check("error", 32'(sal_error), 32'(rej));
    for (int i = 0; i < bp; i++) begin
      step();
      check("bp_valido", {30'd0, sal_valido, ent_listo}, 32'b10);
      check("bp_resultado", 32'(sal_resultado), 32'(exp_res));
    end
    sal_listo = 1'b1;
    step();
    check("post_handshake", {30'd0, sal_valido, ent_listo}, 32'b01);
    check("no_acepta_en_hs", {13'd0, Codigo_OP, Dato0, Dato1}, {13'd0, last_op, last_a, last_b});
    ent_valido = 1'b0;
    $display("req op=%0d a=%02h b=%02h bp=%0d -> res=%02h err=%0b lat=%0d", op, a, b, bp, sal_resultado, sal_error, lat);
  endtask

  initial begin
    logic [2:0] op;
    logic [7:0] a, b;
    #3;
    check("rst_salidas", {8'd0, ent_listo, sal_valido, sal_error, sal_resultado, Codigo_OP, 2'd0},
          32'd0);
    check("rst_datos", {16'd0, Dato0, Dato1}, 32'd0);
    #9 rst_n = 1'b1;
    #1 check("listo_tras_rst_pre", 32'(ent_listo), 32'd0);
    step();
    check("listo_tras_rst", 32'(ent_listo), 32'd1);

    do_req(3'd0, 8'h12, 8'h34, 0);
    do_req(3'd2, 8'h05, 8'h06, 0);
    do_req(3'd1, 8'h10, 8'h20, 5);
    do_req(3'd3, 8'h09, 8'h00, 0);
    do_req(3'd6, 8'h0A, 8'h0B, 1);
    do_req(3'd4, 8'h17, 8'h05, 2);

    // Reset while in EJECUTA.
    for (int i = 0; i < 50 && !ent_listo; i++) step();
    ent_valido = 1'b1; ent_codigo = 3'd0; ent_dato0 = 8'h55; ent_dato1 = 8'h22;
    step();
    ent_valido = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1 check("rst_async", {8'd0, ent_listo, sal_valido, sal_error, sal_resultado, Codigo_OP, 2'd0}, 32'd0);
    check("rst_async_datos", {16'd0, Dato0, Dato1}, 32'd0);
    last_op = '0; last_a = '0; last_b = '0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("sin_valido_viejo", 32'(sal_valido), 32'd0);
    end
    check("listo_tras_rst2", 32'(ent_listo), 32'd1);
    do_req(3'd0, 8'hF0, 8'h20, 1);

    for (int n = 0; n < 16; n++) begin
      op = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      do_req(op, a, b, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
